// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell reused over WIDTH cycles with a registered carry.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_s_c, fa_co_c, last_bit_c;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Single full-adder cell fed by the operand LSBs and the fed-back carry
  always_comb begin
    fa_s_c     = a_q[0] ^ b_q[0] ^ carry_q;
    fa_co_c    = (a_q[0] & b_q[0]) | (b_q[0] & carry_q) | (a_q[0] & carry_q);
    last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        sum_d   = {fa_s_c, sum_q[WIDTH-1:1]};
        carry_d = fa_co_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit_c) begin
          cout_d  = fa_co_c;
`ifdef SERIAL_ADDER_OVF_EN
          // Carry into the MSB differs from carry out of it on signed overflow
          ovf_d   = carry_q ^ fa_co_c;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus randomized traffic vs an arithmetic model.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int failures = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference: full-precision unsigned sum
  function automatic logic [W:0] model_sum(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic cv);
    return {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
  endfunction

  // Reference: signed overflow from operand and result sign bits
  function automatic logic model_ovf(input logic [W-1:0] av, input logic [W-1:0] bv,
                                     input logic cv);
    logic [W:0] r;
    r = model_sum(av, bv, cv);
    return (av[W-1] == bv[W-1]) && (r[W-1] != av[W-1]);
  endfunction

  // Present operands until accepted; returns at the negedge after the handshake edge
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                      output bit ok);
    int n;
    @(negedge clk);
    in_valid = 1'b1; a = av; b = bv; cin = cv;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid; optional random in_valid noise that must be ignored
  task automatic wait_out(input bit noise, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 4*W) begin
      in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b sum=%h cout=%b, required 1 0 00 0",
               in_ready, out_valid, sum, cout);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf: ovf=%b required 0", ovf);
    end
`endif
  endtask

  // Run one directed operation, check latency, result, then complete the handshake
  task automatic test_directed(input string name, input logic [W-1:0] av,
                               input logic [W-1:0] bv, input logic cv);
    bit ok;
    int cyc;
    logic [W:0] exp;
    exp = model_sum(av, bv, cv);
    send(av, bv, cv, ok);
    wait_out(1'b0, cyc);
    checks++;
    if (!ok || cyc != W) begin
      failures++;
      $display("FAIL %s_latency: accepted=%0b cycles=%0d required %0d", name, ok, cyc, W);
    end
    checks++;
    if ({cout, sum} !== exp) begin
      failures++;
      $display("FAIL %s_sum: cout=%b sum=%h required cout=%b sum=%h", name, cout, sum,
               exp[W], exp[W-1:0]);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf !== model_ovf(av, bv, cv)) begin
      failures++;
      $display("FAIL %s_ovf: ovf=%b required %b", name, ovf, model_ovf(av, bv, cv));
    end
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {cout, sum} !== exp) begin
      failures++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b cout/sum=%h required 0 1 %h",
               name, out_valid, in_ready, {cout, sum}, exp);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    logic [W:0] exp;
    exp = model_sum(8'h3C, 8'hC5, 1'b1);
    send(8'h3C, 8'hC5, 1'b1, ok);
    wait_out(1'b0, cyc);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; a = 8'h11; b = 8'h22; cin = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== exp) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%b in_ready=%b cout/sum=%h required 1 0 %h",
                 i, out_valid, in_ready, {cout, sum}, exp);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {cout, sum} !== exp) begin
      failures++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b cout/sum=%h required 0 1 %h",
               out_valid, in_ready, {cout, sum}, exp);
    end
    // Stray pulses during DONE must not have started a new operation
    repeat (W + 2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_no_load: out_valid=%b in_ready=%b required 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    send(8'hF0, 8'h0F, 1'b1, ok);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== '0 || cout !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_run_async: out_valid=%b in_ready=%b sum=%h cout=%b required 0 1 00 0",
               out_valid, in_ready, sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== '0 || cout !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_run_release: out_valid=%b in_ready=%b sum=%h cout=%b required 0 1 00 0",
               out_valid, in_ready, sum, cout);
    end
    test_directed("after_reset", 8'hAA, 8'h55, 1'b1);
  endtask

  task automatic test_random();
    bit ok;
    int cyc;
    int done_cnt;
    logic [W-1:0] av, bv;
    logic cv;
    logic [W:0] exp;
    done_cnt = 0;
    for (int t = 0; t < 1000; t++) begin
      av = W'($urandom); bv = W'($urandom); cv = 1'($urandom);
      if (t % 50 == 0) begin
        av = '1; bv = W'(t / 50); cv = 1'(t / 100);
      end
      exp = model_sum(av, bv, cv);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(av, bv, cv, ok);
      wait_out(1'b1, cyc);
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (!ok || cyc != W || out_valid !== 1'b1 || {cout, sum} !== exp) begin
        failures++;
        $display("FAIL random[%0d]: a=%h b=%h cin=%b cycles=%0d out_valid=%b cout/sum=%h required %0d 1 %h",
                 t, av, bv, cv, cyc, out_valid, {cout, sum}, W, exp);
      end
`ifdef SERIAL_ADDER_OVF_EN
      checks++;
      if (ovf !== model_ovf(av, bv, cv)) begin
        failures++;
        $display("FAIL random_ovf[%0d]: ovf=%b required %b", t, ovf, model_ovf(av, bv, cv));
      end
`endif
      if (out_valid === 1'b1) done_cnt++;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL random_handshake[%0d]: out_valid=%b in_ready=%b required 0 1",
                 t, out_valid, in_ready);
      end
    end
    checks++;
    if (done_cnt != 1000) begin
      failures++;
      $display("FAIL random_count: results=%0d required 1000", done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_directed("basic", 8'h0F, 8'h01, 1'b0);
    test_directed("carry_out", 8'hFF, 8'h01, 1'b0);
    test_directed("signed_ovf", 8'h7F, 8'h01, 1'b0);
    test_directed("neg_ovf", 8'h80, 8'hFF, 1'b0);
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
